param_ram: RTL and testbench

// Single-port synchronous RAM for the cache subsystem. It is parametrised in data width and depth.
// - Byte-enabled writes.
// - Registered read path of configurable latency with a valid/ready request handshake.
// - Hardware init sequencer that fills the array after reset. Test benches no longer preload memory.

---
 rtl/ram_pkg.sv | 18 +
 rtl/ram_array.sv | 28 ++
 rtl/param_ram.sv | 116 +++++++++++
 tb/tb_param_ram.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the parameterised cache RAM.
// ident_word gives the init fill value for word k, sized to the data width.
package ram_pkg;

    typedef enum logic {S_INIT, S_READY} state_t;

    localparam int INIT_NONE  = 0;
    localparam int INIT_IDENT = 1;

    // Low data_w bits of k; widths beyond the address width come out zero-extended.
    function automatic logic [63:0] ident_word(input logic [31:0] k, input int data_w);
        logic [63:0] w;
        w = {32'd0, k};
        if (data_w < 64) w = w & ((64'd1 << data_w) - 64'd1);
        return w;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Storage core: one byte-enabled write and one registered read per cycle.
// No reset so it maps onto block RAM.
module ram_array #(
    parameter  int ADDR_W = 11,
    parameter  int DATA_W = 8,
    localparam int NBYTES = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [NBYTES-1:0] be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] rdata
);

    logic [NBYTES-1:0][7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be[i]) mem[addr][i] <= wdata[8*i +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/param_ram.sv
// Single-port cache RAM: init sequencer, request handshake and a read
// response pipeline of RD_LAT cycles wrapped around ram_array.
module param_ram
    import ram_pkg::*;
#(
    parameter  int ADDR_W    = 11,
    parameter  int DATA_W    = 8,
    parameter  int RD_LAT    = 1,
    parameter  int INIT_MODE = 1,
    localparam int NBYTES    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [NBYTES-1:0] req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done
);

    state_t              state;
    logic [ADDR_W-1:0]   init_cnt;
    logic                acc, rd_acc, wr_acc;
    logic                arr_we;
    logic [NBYTES-1:0]   arr_be;
    logic [ADDR_W-1:0]   arr_addr;
    logic [DATA_W-1:0]   arr_wdata;
    logic [DATA_W-1:0]   arr_rdata;
    logic [RD_LAT:1]     vld_pipe;

    assign acc    = req_valid & req_ready;
    assign rd_acc = acc & ~req_wr;
    assign wr_acc = acc & req_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            init_cnt  <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (INIT_MODE == INIT_NONE || init_cnt == '1) begin
                        state     <= S_READY;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                S_READY: state <= S_READY;
                default: state <= S_INIT;
            endcase
        end
    end

    // The fill owns the write port until the sequencer hands over to requests.
    always_comb begin
        arr_we    = wr_acc;
        arr_be    = req_be;
        arr_addr  = req_addr;
        arr_wdata = req_wdata;
        if (state == S_INIT) begin
            arr_we    = (INIT_MODE == INIT_IDENT);
            arr_be    = '1;
            arr_addr  = init_cnt;
            arr_wdata = DATA_W'(ident_word(32'(init_cnt), DATA_W));
        end
    end

    ram_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (arr_be),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .re    (rd_acc),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_acc;
            for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign rsp_valid = vld_pipe[RD_LAT];

    generate
        if (RD_LAT == 1) begin : g_lat1
            // Array register holds between reads; mask it to zero until the first response.
            logic have_rsp;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) have_rsp <= 1'b0;
                else        have_rsp <= have_rsp | rd_acc;
            end
            assign rsp_rdata = have_rsp ? arr_rdata : '0;
        end else begin : g_lat2
            logic [DATA_W-1:0] dout_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)           dout_q <= '0;
                else if (vld_pipe[1]) dout_q <= arr_rdata;
            end
            assign rsp_rdata = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_param_ram.sv
// Scoreboard bench for param_ram: three configurations driven from a
// reference memory model, responses checked by per-instance monitors.
module tb_param_ram;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec = 0;
    int err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- instance A: defaults ----------------
    logic        rst_a = 1'b0;
    logic        a_valid = 1'b0, a_wr = 1'b0, a_be = 1'b0;
    logic [10:0] a_addr = '0;
    logic [7:0]  a_wdata = '0;
    logic        a_ready, a_rsp_valid, a_init_done;
    logic [7:0]  a_rsp_rdata;

    param_ram dut_a (
        .clk(clk), .rst_n(rst_a), .req_valid(a_valid), .req_ready(a_ready),
        .req_wr(a_wr), .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .init_done(a_init_done)
    );

    // ---------------- instance B: 32-bit words, two-cycle reads ----------------
    logic        rst_b = 1'b0;
    logic        b_valid = 1'b0, b_wr = 1'b0;
    logic [3:0]  b_be = '0;
    logic [4:0]  b_addr = '0;
    logic [31:0] b_wdata = '0;
    logic        b_ready, b_rsp_valid, b_init_done;
    logic [31:0] b_rsp_rdata;

    param_ram #(.ADDR_W(5), .DATA_W(32), .RD_LAT(2), .INIT_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_b), .req_valid(b_valid), .req_ready(b_ready),
        .req_wr(b_wr), .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .init_done(b_init_done)
    );

    // ---------------- instance C: no init fill ----------------
    logic        rst_c = 1'b0;
    logic        c_valid = 1'b0, c_wr = 1'b0, c_be = 1'b0;
    logic [3:0]  c_addr = '0;
    logic [7:0]  c_wdata = '0;
    logic        c_ready, c_rsp_valid, c_init_done;
    logic [7:0]  c_rsp_rdata;

    param_ram #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1), .INIT_MODE(0)) dut_c (
        .clk(clk), .rst_n(rst_c), .req_valid(c_valid), .req_ready(c_ready),
        .req_wr(c_wr), .req_addr(c_addr), .req_wdata(c_wdata), .req_be(c_be),
        .rsp_valid(c_rsp_valid), .rsp_rdata(c_rsp_rdata), .init_done(c_init_done)
    );

    // ---------------- reference models and scoreboards ----------------
    logic [7:0]  ma [2048];
    logic [31:0] mb [32];
    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea, eb;
    int          b_rsp_seen = 0;
    bit          done_a = 0, done_b = 0, done_c = 0;

    task automatic a_ident();
        for (int k = 0; k < 2048; k++) ma[k] = 8'(k % 256);
    endtask

    task automatic b_ident();
        for (int k = 0; k < 32; k++) mb[k] = 32'(k);
    endtask

    // Called #1 after a rising edge; the request is presented to the next edge.
    task automatic a_op(input logic v, input logic wr, input logic [10:0] ad,
                        input logic [7:0] wd, input logic be);
        a_valid = v; a_wr = wr; a_addr = ad; a_wdata = wd; a_be = be;
        if (v && a_ready) begin
            if (wr) begin
                if (be) ma[ad] = wd;
            end else begin
                qa.push_back('{32'(ma[ad]), cyc + 1});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic b_op(input logic v, input logic wr, input logic [4:0] ad,
                        input logic [31:0] wd, input logic [3:0] be);
        b_valid = v; b_wr = wr; b_addr = ad; b_wdata = wd; b_be = be;
        if (v && b_ready) begin
            if (wr) begin
                for (int i = 0; i < 4; i++) if (be[i]) mb[ad][8*i +: 8] = wd[8*i +: 8];
            end else begin
                qb.push_back('{mb[ad], cyc + 2});
            end
        end
        @(posedge clk); #1;
    endtask

    // Counts edges from release until init_done, firing ignored writes meanwhile.
    task automatic a_wait_init(output int n);
        n = 0;
        while (!a_init_done && n < 5000) begin
            a_valid = 1'b1; a_wr = 1'b1; a_be = 1'b1;
            a_addr = 11'($urandom); a_wdata = 8'h55;
            @(posedge clk); #1;
            n++;
        end
        a_valid = 1'b0;
    endtask

    task automatic b_wait_init(output int n);
        n = 0;
        while (!b_init_done && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    always @(negedge clk) begin
        if (a_rsp_valid) begin
            if (qa.size() == 0) chk("a_unexpected_rsp", a_rsp_valid, 0);
            else begin
                ea = qa.pop_front();
                chk("a_rdata", a_rsp_rdata, ea.d);
                chk("a_latency", cyc, ea.due);
            end
        end else if (qa.size() != 0 && qa[0].due <= cyc) begin
            chk("a_missing_rsp", a_rsp_valid, 1);
            void'(qa.pop_front());
        end
    end

    always @(negedge clk) begin
        if (b_rsp_valid) begin
            b_rsp_seen++;
            if (qb.size() == 0) chk("b_unexpected_rsp", b_rsp_valid, 0);
            else begin
                eb = qb.pop_front();
                chk("b_rdata", b_rsp_rdata, eb.d);
                chk("b_latency", cyc, eb.due);
            end
        end else if (qb.size() != 0 && qb[0].due <= cyc) begin
            chk("b_missing_rsp", b_rsp_valid, 1);
            void'(qb.pop_front());
        end
    end

    // ---------------- stimulus A ----------------
    initial begin
        int n;
        logic [10:0] rd_pts [4];
        rd_pts[0] = 11'h000; rd_pts[1] = 11'h0FF; rd_pts[2] = 11'h100; rd_pts[3] = 11'h7FF;
        repeat (3) @(posedge clk);
        #1;
        chk("a_rst_init_done", a_init_done, 0);
        chk("a_rst_ready", a_ready, 0);
        chk("a_rst_rsp_valid", a_rsp_valid, 0);
        chk("a_rst_rdata", a_rsp_rdata, 0);
        rst_a = 1'b1;
        a_wait_init(n);
        chk("a_init_cycles", n, 2048);
        chk("a_ready_after_init", a_ready, 1);
        a_ident();
        for (int i = 0; i < 4; i++) a_op(1, 0, rd_pts[i], 0, 0);
        a_op(1, 1, 11'h010, 8'h3C, 1);
        a_op(1, 0, 11'h010, 0, 0);
        for (int i = 0; i < 8; i++) a_op(1, 0, 11'(i), 0, 0);
        a_op(1, 1, 11'h003, 8'hEE, 0);
        a_op(1, 0, 11'h003, 0, 0);
        for (int i = 0; i < 400; i++)
            a_op($urandom_range(0, 3) != 0, 1'($urandom), 11'($urandom),
                 8'($urandom), 1'($urandom));
        a_op(0, 0, 0, 0, 0);
        repeat (3) a_op(0, 0, 0, 0, 0);
        rst_a = 1'b0;
        #1;
        chk("a_ready_drop", a_ready, 0);
        chk("a_init_done_drop", a_init_done, 0);
        chk("a_rdata_cleared", a_rsp_rdata, 0);
        @(posedge clk); #1;
        rst_a = 1'b1;
        repeat (1000) begin @(posedge clk); #1; end
        rst_a = 1'b0;
        #1;
        chk("a_midinit_ready", a_ready, 0);
        chk("a_midinit_done", a_init_done, 0);
        @(posedge clk); #1;
        rst_a = 1'b1;
        a_wait_init(n);
        chk("a_reinit_cycles", n, 2048);
        a_ident();
        for (int i = 0; i < 100; i++)
            a_op(1, 1'($urandom_range(0, 3) == 0), 11'($urandom), 8'($urandom), 1'($urandom));
        a_op(0, 0, 0, 0, 0);
        repeat (4) a_op(0, 0, 0, 0, 0);
        done_a = 1;
    end

    // ---------------- stimulus B ----------------
    initial begin
        int n, seen;
        repeat (2) @(posedge clk);
        #1;
        chk("b_rst_rdata", b_rsp_rdata, 0);
        rst_b = 1'b1;
        b_wait_init(n);
        chk("b_init_cycles", n, 32);
        b_ident();
        b_op(1, 1, 5'd5, 32'hAABBCCDD, 4'b0101);
        b_op(1, 0, 5'd5, 0, 0);
        b_op(1, 1, 5'h10, 32'h0000003C, 4'hF);
        b_op(1, 0, 5'h10, 0, 0);
        for (int i = 0; i < 200; i++)
            b_op($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom),
                 $urandom, 4'($urandom));
        repeat (4) b_op(0, 0, 0, 0, 0);
        b_op(1, 0, 5'd1, 0, 0);
        b_op(1, 0, 5'd2, 0, 0);
        b_valid = 1'b0;
        rst_b = 1'b0;
        qb.delete();
        seen = b_rsp_seen;
        #1;
        chk("b_rst_rsp_valid", b_rsp_valid, 0);
        chk("b_rst_rdata_inflight", b_rsp_rdata, 0);
        @(posedge clk); #1;
        rst_b = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        chk("b_no_rsp_after_reset", b_rsp_seen, seen);
        b_wait_init(n);
        b_ident();
        for (int i = 0; i < 60; i++)
            b_op(1, 1'($urandom_range(0, 3) == 0), 5'($urandom), $urandom, 4'($urandom));
        repeat (4) b_op(0, 0, 0, 0, 0);
        done_b = 1;
    end

    // ---------------- stimulus C ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_c = 1'b1;
        #1;
        chk("c_done_before_edge", c_init_done, 0);
        @(posedge clk); #1;
        chk("c_init_done_1cyc", c_init_done, 1);
        chk("c_ready_1cyc", c_ready, 1);
        c_valid = 1'b1; c_wr = 1'b1; c_addr = 4'd3; c_wdata = 8'h5A; c_be = 1'b1;
        @(posedge clk); #1;
        c_wr = 1'b0;
        @(posedge clk); #1;
        c_valid = 1'b0;
        chk("c_rsp_valid", c_rsp_valid, 1);
        chk("c_rsp_rdata", c_rsp_rdata, 8'h5A);
        @(posedge clk); #1;
        chk("c_rsp_pulse", c_rsp_valid, 0);
        chk("c_rdata_held", c_rsp_rdata, 8'h5A);
        done_c = 1;
    end

    initial begin
        wait (done_a && done_b && done_c);
        @(negedge clk);
        chk("a_pending_at_end", qa.size(), 0);
        chk("b_pending_at_end", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: timeout at cycle %0d, required completion", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err + 1);
        $fatal(1, "timeout");
    end

endmodule
